// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch with start/stop/clear; optional lap display hold under STOPWATCH_LAP_HOLD_EN
module stopwatch_counter #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
  input  logic       lap,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       running,
  output logic       rollover
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUNNING, PAUSED} state_t;
  state_t state;
  logic ss_q, ss_edge, tick, at_max, c0, c1, c2;
  logic [PW-1:0] pre;
  logic [3:0] mt, mo, st, so;
  assign ss_edge = start_stop & ~ss_q;
  assign tick = state == RUNNING && pre == PW'(TICK_DIV - 1);
  assign at_max = {mt, mo, st, so} == 16'h5959;
  assign c0 = so == 4'd9;
  assign c1 = c0 && st == 4'd5;
  assign c2 = c1 && mo == 4'd9;
  assign running = state == RUNNING;
  // control FSM, prescaler and BCD time-of-count; clear outranks tick and start_stop
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ss_q <= 1'b0;
      pre <= '0;
      {mt, mo, st, so} <= '0;
      rollover <= 1'b0;
    end else begin
      ss_q <= start_stop;
      rollover <= !clear && tick && at_max;
      if (clear) begin
        state <= IDLE;
        pre <= '0;
        {mt, mo, st, so} <= '0;
      end else begin
        if (state == RUNNING) pre <= tick ? '0 : pre + 1'b1;
        if (tick) begin
          so <= c0 ? 4'd0 : so + 4'd1;
          st <= c0 ? (st == 4'd5 ? 4'd0 : st + 4'd1) : st;
          mo <= c1 ? (mo == 4'd9 ? 4'd0 : mo + 4'd1) : mo;
          mt <= c2 ? (mt == 4'd5 ? 4'd0 : mt + 4'd1) : mt;
        end
        if (ss_edge) state <= state == RUNNING ? PAUSED : RUNNING;
      end
    end
  end
`ifdef STOPWATCH_LAP_HOLD_EN
  logic lap_q, hold;
  logic [15:0] held;
  // lap edges toggle a frozen snapshot of the count; ignored while IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= 1'b0;
      hold <= 1'b0;
      held <= '0;
    end else begin
      lap_q <= lap;
      if (clear) hold <= 1'b0;
      else if (lap && !lap_q && state != IDLE) begin
        hold <= ~hold;
        held <= {mt, mo, st, so};
      end
    end
  end
  assign {min_tens, min_ones, sec_tens, sec_ones} = hold ? held : {mt, mo, st, so};
`else
  assign {min_tens, min_ones, sec_tens, sec_ones} = {mt, mo, st, so};
`endif
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: seconds-based reference model plus directed scenarios for stopwatch_counter
module tb_stopwatch_counter;
  localparam int TD = 4;
  logic clk = 1'b0, reset = 1'b1, start_stop = 1'b0, clear = 1'b0, lap = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic running, rollover;
  logic [17:0] act;
  int checks = 0, passed = 0;
  bit chk_en = 1'b0;
  int m_state = 0, m_pre = 0, m_secs = 0, m_held = 0;
  bit m_prev_ss = 1'b0, m_prev_lap = 1'b0, m_roll = 1'b0, m_hold = 1'b0;
  bit tk, se, le;

  always #5 clk = ~clk;

  stopwatch_counter #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
`ifdef STOPWATCH_LAP_HOLD_EN
    .lap(lap),
`endif
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .rollover(rollover)
  );

  assign act = {min_tens, min_ones, sec_tens, sec_ones, running, rollover};

  function automatic logic [15:0] bcd(int d);
    return {4'(d / 600), 4'((d / 60) % 10), 4'((d % 60) / 10), 4'(d % 10)};
  endfunction

  function automatic logic [17:0] expv();
    return {bcd(m_hold ? m_held : m_secs), m_state == 1, m_roll};
  endfunction

  // model: elapsed whole seconds modulo one hour, states 0=idle 1=running 2=paused
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_state = 0; m_pre = 0; m_secs = 0; m_held = 0;
      m_prev_ss = 0; m_prev_lap = 0; m_roll = 0; m_hold = 0;
    end else if (clear) begin
      m_state = 0; m_pre = 0; m_secs = 0; m_roll = 0; m_hold = 0;
      m_prev_ss = start_stop; m_prev_lap = lap;
    end else begin
      tk = m_state == 1 && m_pre == TD - 1;
      se = start_stop && !m_prev_ss;
      le = lap && !m_prev_lap;
      m_roll = tk && m_secs == 3599;
`ifdef STOPWATCH_LAP_HOLD_EN
      if (le && m_state != 0) begin
        if (!m_hold) m_held = m_secs;
        m_hold = !m_hold;
      end
`endif
      if (m_state == 1) m_pre = tk ? 0 : m_pre + 1;
      if (tk) m_secs = (m_secs + 1) % 3600;
      if (se) m_state = m_state == 1 ? 2 : 1;
      m_prev_ss = start_stop;
      m_prev_lap = lap;
    end
  end

  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checks++;
      if (act === expv()) passed++;
      else $display("FAIL model t=%0t act=%h req=%h", $time, act, expv());
    end
  end

  task automatic chk(input string name, input logic [17:0] a, input logic [17:0] e);
    checks++;
    if (a === e) passed++;
    else $display("FAIL %s act=%h req=%h", name, a, e);
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
  endtask

  task automatic clr();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge clk);
    lap = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("reset", act, 18'h0);
    pulse_ss();
    repeat (40) @(negedge clk);
    chk("run40", act, {16'h0010, 2'b10});
    chk("model_run40", expv(), {16'h0010, 2'b10});
    clr();
    chk("clear_idle", act, 18'h0);
    pulse_ss();
    repeat (29) @(negedge clk);
    pulse_ss();
    chk("pause", act, {16'h0007, 2'b00});
    repeat (20) @(negedge clk);
    chk("pause_hold", act, {16'h0007, 2'b00});
    pulse_ss();
    chk("resume", act, {16'h0007, 2'b10});
    @(negedge clk);
    chk("resume_1", act, {16'h0007, 2'b10});
    @(negedge clk);
    chk("resume_2", act, {16'h0008, 2'b10});
    clr();
    pulse_ss();
    repeat (828) @(negedge clk);
    chk("at_0327", act, {16'h0327, 2'b10});
    clear = 1'b1;
    start_stop = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start_stop = 1'b0;
    chk("clear_prio", act, 18'h0);
    repeat (5) @(negedge clk);
    chk("clear_stay", act, 18'h0);
    start_stop = 1'b1;
    repeat (50) @(negedge clk);
    chk("ss_held", act, {16'h0012, 2'b10});
    start_stop = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_mid", act, 18'h0);
    pulse_ss();
    repeat (14392) @(negedge clk);
    chk("at_5958", act, {16'h5958, 2'b10});
    repeat (4) @(negedge clk);
    chk("at_5959", act, {16'h5959, 2'b10});
    repeat (3) @(negedge clk);
    chk("pre_wrap", act, {16'h5959, 2'b10});
    @(negedge clk);
    chk("wrap", act, {16'h0000, 2'b11});
    @(negedge clk);
    chk("wrap_after", act, {16'h0000, 2'b10});
`ifdef STOPWATCH_LAP_HOLD_EN
    clr();
    pulse_lap();
    chk("lap_idle", act, 18'h0);
    pulse_ss();
    repeat (20) @(negedge clk);
    pulse_lap();
    repeat (19) @(negedge clk);
    chk("lap_hold", act, {16'h0005, 2'b10});
    pulse_lap();
    chk("lap_release", act, {16'h0010, 2'b10});
    pulse_lap();
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_hold", act, 18'h0);
    pulse_ss();
    repeat (4) @(negedge clk);
    chk("after_hold_reset", act, {16'h0001, 2'b10});
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
